// File: rtl/alu_operand_stage_pkg.sv
// Shared definitions for the ALU operand stage: opcode encodings, the EX
// payload layout and the opcode legality check (also used by the ALU).
package alu_operand_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 3;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_OR  = 3'b001,
    OP_AND = 3'b100,
    OP_SUB = 3'b101,
    OP_XOR = 3'b110
  } alu_op_e;

  // Payload held in the EX pipeline register alongside its valid bit.
  typedef struct packed {
    logic [2:0]        inst;
    logic [DATA_W-1:0] da;
    logic [DATA_W-1:0] db;
    logic [REG_AW-1:0] rd;
    logic              wb;
  } ex_stage_t;

  function automatic logic is_valid_op(input logic [2:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_ADD, OP_OR, OP_AND, OP_SUB, OP_XOR: ok = 1'b1;
      default:                               ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_operand_stage_regfile.sv
// NREG x DATA_W register file: two combinational read ports, one synchronous
// write port. Register 0 always reads as zero and ignores writes.
module alu_operand_stage_regfile
  import alu_operand_stage_pkg::*;
#(
  parameter int NREG = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] i_ra,
  input  logic [REG_AW-1:0] i_rb,
  output logic [DATA_W-1:0] o_da,
  output logic [DATA_W-1:0] o_db,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_wa,
  input  logic [DATA_W-1:0] i_wd
);

  logic [DATA_W-1:0] r_mem [NREG];

  // Storage update: clear everything on reset, otherwise one write per edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we && (i_wa != '0)) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  assign o_da = (i_ra == '0) ? '0 : r_mem[i_ra];
  assign o_db = (i_rb == '0) ? '0 : r_mem[i_rb];

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-fetch / execute-issue stage in front of the 32-bit ALU. Reads the
// register file, forwards the retiring ALU result to a same-edge consumer,
// and holds a registered {inst, da, db} triple for the ALU.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int NREG = 8,
  parameter int IMMW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_ra,
  input  logic [REG_AW-1:0] in_rb,
  input  logic              in_use_imm,
  input  logic [IMMW-1:0]   in_imm,
  output logic [2:0]        alu_inst,
  output logic [DATA_W-1:0] alu_da,
  output logic [DATA_W-1:0] alu_db,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              out_ready,
  output logic              res_valid,
  output logic [REG_AW-1:0] res_rd,
  output logic [DATA_W-1:0] res_data
);

  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMMW-1:0] imm);
    return {{(DATA_W-IMMW){imm[IMMW-1]}}, imm};
  endfunction

  logic              r_vld_p1;
  ex_stage_t         r_ex_p1;

  logic              w_accept;
  logic              w_retire;
  logic              w_fwd_a;
  logic              w_fwd_b;
  logic [DATA_W-1:0] w_rf_da;
  logic [DATA_W-1:0] w_rf_db;
  logic [DATA_W-1:0] w_opa;
  logic [DATA_W-1:0] w_opb;
  logic              w_op_ok;

  // ---- operand fetch (stage 0) ----
  assign in_ready = !r_vld_p1 || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_retire = r_vld_p1 && out_ready && r_ex_p1.wb;

  alu_operand_stage_regfile #(.NREG(NREG)) u_rf (
    .clk  (clk),
    .rst  (rst),
    .i_ra (in_ra),
    .i_rb (in_rb),
    .o_da (w_rf_da),
    .o_db (w_rf_db),
    .i_we (w_retire),
    .i_wa (r_ex_p1.rd),
    .i_wd (alu_out)
  );

  // A result landing in the regfile on this very edge is not visible through
  // the read port yet, so the consumer takes it straight from the ALU.
  assign w_fwd_a = w_retire && (r_ex_p1.rd != '0) && (r_ex_p1.rd == in_ra);
  assign w_fwd_b = w_retire && (r_ex_p1.rd != '0) && (r_ex_p1.rd == in_rb);

  assign w_opa   = w_fwd_a ? alu_out : w_rf_da;
  assign w_opb   = in_use_imm ? sext_imm(in_imm) :
                   (w_fwd_b   ? alu_out : w_rf_db);
  assign w_op_ok = is_valid_op(in_op);

  // ---- EX register (stage 1) ----
  // EX register: loads on accept, drains to empty when nothing arrives,
  // holds while the downstream stalls. Unknown opcodes travel as a no-wb ADD.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
      r_ex_p1  <= '0;
    end else if (in_ready) begin
      r_vld_p1 <= in_valid;
      if (w_accept) begin
        r_ex_p1.inst <= w_op_ok ? in_op : OP_ADD;
        r_ex_p1.da   <= w_opa;
        r_ex_p1.db   <= w_opb;
        r_ex_p1.rd   <= in_rd;
        r_ex_p1.wb   <= w_op_ok;
      end
    end
  end

  assign alu_inst  = r_ex_p1.inst;
  assign alu_da    = r_ex_p1.da;
  assign alu_db    = r_ex_p1.db;
  assign res_valid = r_vld_p1 && r_ex_p1.wb && (r_ex_p1.rd != '0) && out_ready;
  assign res_rd    = r_ex_p1.rd;
  assign res_data  = alu_out;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage with a behavioural ALU in the loop.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [2:0]  in_rd;
  logic [2:0]  in_ra;
  logic [2:0]  in_rb;
  logic        in_use_imm;
  logic [15:0] in_imm;
  logic [2:0]  alu_inst;
  logic [31:0] alu_da;
  logic [31:0] alu_db;
  logic [31:0] alu_out;
  logic        out_ready;
  logic        res_valid;
  logic [2:0]  res_rd;
  logic [31:0] res_data;

  int n_checks = 0;
  int n_errors = 0;
  int n_retire = 0;
  int base_retire;

  always #5 clk = ~clk;

  alu_operand_stage #(.NREG(8), .IMMW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_ra      (in_ra),
    .in_rb      (in_rb),
    .in_use_imm (in_use_imm),
    .in_imm     (in_imm),
    .alu_inst   (alu_inst),
    .alu_da     (alu_da),
    .alu_db     (alu_db),
    .alu_out    (alu_out),
    .out_ready  (out_ready),
    .res_valid  (res_valid),
    .res_rd     (res_rd),
    .res_data   (res_data)
  );

  // Reference ALU driven by the stage outputs.
  always_comb begin
    alu_out = 32'h0;
    case (alu_inst)
      3'b000:  alu_out = alu_da + alu_db;
      3'b101:  alu_out = alu_da - alu_db;
      3'b100:  alu_out = alu_da & alu_db;
      3'b001:  alu_out = alu_da | alu_db;
      3'b110:  alu_out = alu_da ^ alu_db;
      default: alu_out = 32'h0;
    endcase
  end

  always @(posedge clk) if (!rst && res_valid) n_retire <= n_retire + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra,
                       input logic [2:0] rb, input logic use_imm, input logic [15:0] imm);
    in_valid   = 1'b1;
    in_op      = op;
    in_rd      = rd;
    in_ra      = ra;
    in_rb      = rb;
    in_use_imm = use_imm;
    in_imm     = imm;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
    in_op = 3'b000; in_rd = 3'd0; in_ra = 3'd0; in_rb = 3'd0;
    in_use_imm = 1'b0; in_imm = 16'h0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("rst_inst", {29'h0, alu_inst}, 32'h0);
    check("rst_da", alu_da, 32'h0);
    check("rst_db", alu_db, 32'h0);
    check("rst_res_valid", {31'h0, res_valid}, 32'h0);
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    rst = 1'b0;

    // Every register reads back as zero after reset.
    for (int k = 1; k < 8; k++) begin
      drive(3'b000, 3'd0, 3'(k), 3'(k), 1'b0, 16'h0);
      step();
      check($sformatf("rd0_a_r%0d", k), alu_da, 32'h0);
      check($sformatf("rd0_b_r%0d", k), alu_db, 32'h0);
    end

    // Immediate with sign extension, writeback to r1.
    drive(3'b000, 3'd1, 3'd0, 3'd0, 1'b1, 16'hFFFF);
    step();
    check("imm_da", alu_da, 32'h0);
    check("imm_db", alu_db, 32'hFFFF_FFFF);
    check("imm_res_valid", {31'h0, res_valid}, 32'h1);
    check("imm_res_rd", {29'h0, res_rd}, 32'd1);
    check("imm_res_data", res_data, 32'hFFFF_FFFF);

    // Back-to-back dependent chain.
    drive(3'b000, 3'd2, 3'd0, 3'd0, 1'b1, 16'd5);
    step();
    check("add_r2_db", alu_db, 32'd5);
    check("add_r2_data", res_data, 32'd5);
    drive(3'b101, 3'd3, 3'd2, 3'd2, 1'b0, 16'h0);
    step();
    check("sub_inst", {29'h0, alu_inst}, 32'h5);
    check("sub_fwd_da", alu_da, 32'd5);
    check("sub_fwd_db", alu_db, 32'd5);
    check("sub_res_rd", {29'h0, res_rd}, 32'd3);
    check("sub_res_data", res_data, 32'd0);
    drive(3'b110, 3'd4, 3'd3, 3'd2, 1'b0, 16'h0);
    step();
    check("xor_da", alu_da, 32'd0);
    check("xor_db", alu_db, 32'd5);
    check("xor_res_data", res_data, 32'd5);
    drive(3'b000, 3'd0, 3'd1, 3'd4, 1'b0, 16'h0);
    step();
    check("read_r1", alu_da, 32'hFFFF_FFFF);
    check("fwd_r4", alu_db, 32'd5);
    check("rd0_no_res", {31'h0, res_valid}, 32'h0);

    // Stall: AND r7 = r1 & 0xF0 sits in EX while out_ready is low.
    drive(3'b100, 3'd7, 3'd1, 3'd0, 1'b1, 16'h00F0);
    step();
    check("and_da", alu_da, 32'hFFFF_FFFF);
    check("and_db", alu_db, 32'h0000_00F0);
    out_ready = 1'b0;
    drive(3'b000, 3'd1, 3'd7, 3'd0, 1'b1, 16'd1);
    base_retire = n_retire;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("stall%0d_in_ready", c), {31'h0, in_ready}, 32'h0);
      check($sformatf("stall%0d_da", c), alu_da, 32'hFFFF_FFFF);
      check($sformatf("stall%0d_db", c), alu_db, 32'h0000_00F0);
      check($sformatf("stall%0d_inst", c), {29'h0, alu_inst}, 32'h4);
      check($sformatf("stall%0d_res_valid", c), {31'h0, res_valid}, 32'h0);
    end
    out_ready = 1'b1;
    #1;
    check("release_res_valid", {31'h0, res_valid}, 32'h1);
    check("release_res_data", res_data, 32'h0000_00F0);
    check("release_in_ready", {31'h0, in_ready}, 32'h1);
    step();
    check("release_fwd_da", alu_da, 32'h0000_00F0);
    check("release_db", alu_db, 32'd1);
    check("release_one_retire", 32'(n_retire - base_retire), 32'd1);
    drive(3'b000, 3'd0, 3'd7, 3'd1, 1'b0, 16'h0);
    step();
    check("read_r7", alu_da, 32'h0000_00F0);
    check("fwd_r1", alu_db, 32'h0000_00F1);

    // Illegal opcode becomes a no-writeback ADD.
    drive(3'b111, 3'd5, 3'd1, 3'd0, 1'b1, 16'd7);
    step();
    check("bad_op_inst", {29'h0, alu_inst}, 32'h0);
    check("bad_op_res_valid", {31'h0, res_valid}, 32'h0);
    check("bad_op_in_ready", {31'h0, in_ready}, 32'h1);
    check("bad_op_da", alu_da, 32'h0000_00F1);
    drive(3'b000, 3'd0, 3'd5, 3'd5, 1'b0, 16'h0);
    step();
    check("r5_unchanged", alu_da, 32'h0);

    // Reset while OR r6 is stalled in EX.
    drive(3'b001, 3'd6, 3'd1, 3'd0, 1'b1, 16'h0F00);
    step();
    check("or_db", alu_db, 32'h0000_0F00);
    check("or_res_data", res_data, 32'h0000_0FF1);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    #1;
    check("or_stalled_res_valid", {31'h0, res_valid}, 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("midrst_in_ready", {31'h0, in_ready}, 32'h1);
    check("midrst_res_valid", {31'h0, res_valid}, 32'h0);
    check("midrst_da", alu_da, 32'h0);
    drive(3'b000, 3'd0, 3'd6, 3'd1, 1'b0, 16'h0);
    step();
    check("midrst_r6", alu_da, 32'h0);
    check("midrst_r1", alu_db, 32'h0);
    in_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
